// File: rtl/sm_bus.sv
// Snoop side of the MSI coherence controller: looks up broadcast bus requests in a
// direct-mapped line-state table, applies MSI snoop transitions, runs write-backs.
module sm_bus #(
  parameter int LINES    = 4,
  parameter int IDX_W    = 2,
  parameter int TAG_W    = 4,
  parameter int WB_BEATS = 2,
  localparam int BW      = $clog2(WB_BEATS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             busValid,
  input  logic [1:0]       busOp,
  input  logic [IDX_W-1:0] busIndex,
  input  logic [TAG_W-1:0] busTag,
  output logic             busReady,
  output logic             busDone,
  output logic             abortMemAccess,
  output logic             writeBack,
  output logic [BW-1:0]    wbBeat,
  input  logic             cpuUpdate,
  input  logic [IDX_W-1:0] cpuIndex,
  input  logic [TAG_W-1:0] cpuTag,
  input  logic [1:0]       cpuState,
  output logic             cpuReady,
  output logic [1:0]       snoopState,
  output logic             protocolError
);
  typedef enum logic [1:0] {IDLE, WB, DONE} state_t;

  // Resolved outcome of a snoop, decided once at acceptance.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [1:0]       nst;
    logic             wb;
    logic             perr;
  } cap_t;

  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
  localparam logic [1:0] OP_RD = 2'b01, OP_WR = 2'b10, OP_INV = 2'b11;

  state_t           state, nxt;
  cap_t             cap, cap_d, cur;
  logic [BW-1:0]    beat;
  logic [TAG_W-1:0] tagq [LINES];
  logic [1:0]       stq  [LINES];
  logic [1:0]       ent_st;
  logic             accept, hit, enter_done;

  assign ent_st = stq[busIndex];
  assign hit    = (ent_st != ST_I) && (tagq[busIndex] == busTag);
  assign accept = busValid && busReady && (busOp != 2'b00);

  always_comb begin
    cap_d      = '0;
    cap_d.idx  = busIndex;
    cap_d.hit  = hit;
    if (hit) begin
      if (ent_st == ST_S) begin
        cap_d.nst = (busOp == OP_RD) ? ST_S : ST_I;
      end else if (ent_st == ST_M) begin
        cap_d.nst  = (busOp == OP_RD) ? ST_S : ST_I;
        cap_d.wb   = (busOp != OP_INV);
        cap_d.perr = (busOp == OP_INV);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = cap_d.wb ? WB : DONE;
      WB:   if (beat == BW'(WB_BEATS - 1)) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Going IDLE->DONE the captured register isn't loaded yet, so use the live decode.
  assign cur        = (state == IDLE) ? cap_d : cap;
  assign enter_done = (nxt == DONE) && (state != DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cap        <= '0;
      beat       <= '0;
      snoopState <= ST_I;
      for (int i = 0; i < LINES; i++) begin
        tagq[i] <= '0;
        stq[i]  <= ST_I;
      end
    end else begin
      state <= nxt;
      if (accept) cap <= cap_d;
      beat <= (state == WB) ? beat + BW'(1) : '0;
      if (cpuUpdate && cpuReady) begin
        tagq[cpuIndex] <= cpuTag;
        stq[cpuIndex]  <= (cpuState == 2'b11) ? ST_I : cpuState;
      end
      if (enter_done) begin
        snoopState <= cur.nst;
        if (cur.hit) stq[cur.idx] <= cur.nst;
      end
    end
  end

  assign busReady       = (state == IDLE);
  assign busDone        = (state == DONE);
  assign abortMemAccess = (state == DONE) && cap.wb;
  assign protocolError  = (state == DONE) && cap.perr;
  assign writeBack      = (state == WB);
  assign wbBeat         = (state == WB) ? beat : '0;
  assign cpuReady       = (state == IDLE) && !(busValid && (busIndex == cpuIndex));
endmodule

// File: doc/sm_bus.md
# sm_bus

Bus-side (snoop) half of the MSI coherence controller. It watches transactions that other caches broadcast on the shared bus (read miss, write miss, invalidate), looks each one up in a local direct-mapped line-state table, and applies the MSI snoop transitions. When a Modified line is hit, it runs a multi-beat write-back and aborts the memory access. It sits beside the CPU-side state machine; that machine publishes line states into this block's table through the CPU update port.

## Interface
- `LINES`, 4: number of direct-mapped lines; power of two, at least 2.
- `IDX_W`, 2: index width, log2(LINES).
- `TAG_W`, 4: tag width per line.
- `WB_BEATS`, 2: write-back data beats, at least 1.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `busValid`  in  1  snooped bus request present.
- `busOp`  in  2  01 readMiss, 10 writeMiss, 11 invalidate, 00 ignored.
- `busIndex`  in  IDX_W  line index of the bus request.
- `busTag`  in  TAG_W  tag of the bus request.
- `busReady`  out  1  block can accept a bus request this cycle.
- `busDone`  out  1  one-cycle completion pulse.
- `abortMemAccess`  out  1  valid with `busDone`; 1 means this cache supplied the data.
- `writeBack`  out  1  high during write-back beats.
- `wbBeat`  out  log2(WB_BEATS)+1  current write-back beat number.
- `cpuUpdate`  in  1  CPU side writes a line entry.
- `cpuIndex`  in  IDX_W  entry index for the CPU write.
- `cpuTag`  in  TAG_W  entry tag for the CPU write.
- `cpuState`  in  2  entry state: 00 Invalid, 01 Shared, 10 Modified.
- `cpuReady`  out  1  CPU write is accepted this cycle.
- `snoopState`  out  2  registered state of the line addressed by the last accepted bus request.
- `protocolError`  out  1  one-cycle pulse when an invalidate hits a Modified line.

## Operation
- Line-state encoding: 00 Invalid, 01 Shared, 10 Modified. Encoding 11 is never stored; a CPU write of 11 stores 00.
- Reset state of the table: every entry is Invalid with tag 0.
- Reset value of outputs:
  - `busReady` = 1.
  - `busDone`, `abortMemAccess`, `writeBack`, `wbBeat`, `snoopState`, `protocolError` = 0.
  - `cpuReady` follows its combinational equation below.
- Control FSM states: IDLE, WB, DONE.
- `busReady` is high only in IDLE.
- A bus request is accepted when `busValid` and `busReady` are both high and `busOp` is not 00. A `busOp` of 00 is dropped with no response.
- Hit rule: hit = (entry state not Invalid) and (entry tag equals `busTag`). Entry state, tag and `busOp` are captured at acceptance.
- Snoop transitions:
  - Miss, or line Invalid: no change; DONE with abort=0.
  - Shared + readMiss: stays Shared; DONE, abort=0.
  - Shared + writeMiss or invalidate: line goes Invalid; DONE, abort=0.
  - Modified + readMiss: WB, then line goes Shared; DONE, abort=1.
  - Modified + writeMiss: WB, then line goes Invalid; DONE, abort=1.
  - Modified + invalidate: line goes Invalid with no write-back; `protocolError` pulses; DONE, abort=0.
- WB state:
  - `writeBack` = 1.
  - `wbBeat` counts 0 to WB_BEATS-1, one step per cycle.
  - After the last beat the FSM moves to DONE.
- DONE state:
  - Table entry updated on entry to DONE.
  - `busDone` = 1 for exactly one cycle; `snoopState` shows the new state.
  - FSM returns to IDLE on the next cycle.
- `cpuReady` = (FSM in IDLE) and not (`busValid` and `busIndex` == `cpuIndex`). When a bus request and a CPU write collide, the bus wins. A `cpuUpdate` while `cpuReady` is 0 is ignored; the CPU side must hold its request and retry.
- An accepted CPU update writes tag and state at the next edge.
- Reset mid-operation: reset takes priority over everything. It aborts WB or DONE immediately, drives all outputs to their reset values, and invalidates the whole table. No `busDone` is issued for the aborted request.

## Timing
- Bus request accepted in cycle T.
- Non-write-back cases:
  - DONE in cycle T+1 with `busDone` = 1.
  - `busReady` high again at T+2.
- Write-back cases:
  - `writeBack` = 1 from T+1 through T+WB_BEATS, with `wbBeat` = 0 .. WB_BEATS-1.
  - `busDone` and `abortMemAccess` = 1 at T+WB_BEATS+1.
  - `busReady` high at T+WB_BEATS+2.
- Throughput: at most one bus request every 2 cycles (non-write-back case).
- The table update is visible to a new lookup in the cycle after `busDone`.

## Test plan
- Reset, then readMiss at idx 1, tag 3 (table empty) → `busDone` at T+1, abort=0, `snoopState`=00, no `writeBack`.
- CPU writes idx 2 = tag 5 Shared, then bus writeMiss at idx 2, tag 5 → T+1 `busDone`, abort=0, `snoopState`=00; a following readMiss at idx 2 also returns 00.
- CPU writes idx 0 = tag 9 Modified, then readMiss at idx 0, tag 9 with WB_BEATS=2 → `writeBack` high at T+1 and T+2 with `wbBeat` 0 then 1; `busDone` and abort=1 at T+3; `snoopState`=01.
- Modified idx 3 tag 1, bus readMiss at idx 3 tag 2 (tag mismatch) → miss: abort=0, entry stays Modified, no `writeBack`.
- Modified idx 1, invalidate at idx 1 same tag → `protocolError` pulse, `busDone` at T+1 with abort=0, entry goes Invalid.
- `cpuUpdate` and `busValid` on the same index in the same cycle → `cpuReady`=0 and the CPU write is dropped. Separately, assert `reset` in the middle of WB → `writeBack` is 0 next cycle, no `busDone`, all entries Invalid.
